// File: rtl/corrosion_grid_pkg.sv
// corrosion_grid_pkg: shared geometry defaults and emitter state encodings for corrosion_grid.
package corrosion_grid_pkg;
    localparam int CORROSION_DX        = 40;
    localparam int CORROSION_DY        = 30;
    localparam int CORROSION_SIZE_LOG2 = 3;
    localparam int CORROSION_GAP       = 8;
    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_EMIT = 3'b010,
        S_WAIT = 3'b100
    } state_t;
endpackage

// File: rtl/corrosion_row_fifo.sv
// corrosion_row_fifo: 2-deep ping-pong buffer of cell rows; a write into a full buffer is dropped
// unless the reader releases an entry in the same cycle.
module corrosion_row_fifo #(
    parameter int DX = 40
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr,
    input  logic [DX-1:0] wdata,
    input  logic          rd,
    output logic [DX-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic          drop
);
    logic [DX-1:0] mem [2];
    logic          wp, rp, wr_ok, rd_ok;
    logic [1:0]    cnt;
    assign full  = cnt == 2'd2;
    assign empty = cnt == 2'd0;
    assign drop  = wr && full && !rd;
    assign wr_ok = wr && !drop;
    assign rd_ok = rd && !empty;
    assign rdata = mem[rp];
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            wp     <= 1'b0;
            rp     <= 1'b0;
            cnt    <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (wr_ok) begin
                mem[wp] <= wdata;
                wp      <= ~wp;
            end
            if (rd_ok) rp <= ~rp;
            cnt <= cnt + 2'(wr_ok) - 2'(rd_ok);
        end
    end
endmodule

// File: rtl/corrosion_grid.sv
// corrosion_grid: reduces each CELL x CELL pixel block to a thresholded cell bit and emits the grid as paced strobes.
// Define CORROSION_ERODE_EN to apply 1x3 horizontal erosion to each cell row before buffering.
module corrosion_grid
    import corrosion_grid_pkg::*;
#(
    parameter int CELL_LOG2 = CORROSION_SIZE_LOG2,
    parameter int DX        = CORROSION_DX,
    parameter int DY        = CORROSION_DY,
    parameter int GAP       = CORROSION_GAP,
    parameter int ACC_W     = 7
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             i_vsync,
    input  logic             i_de,
    input  logic             i_bin,
    input  logic [ACC_W-1:0] i_thresh,
    output logic             o_valid,
    output logic             o_wb,
    output logic             o_frame_done,
    output logic             o_ovf
);
    localparam int W   = DX << CELL_LOG2;
    localparam int H   = DY << CELL_LOG2;
    localparam int PXW = $clog2(W);
    localparam int PYW = $clog2(H);
    localparam int KW  = PXW - CELL_LOG2;
    localparam int CW  = $clog2(DX);
    localparam int RW  = $clog2(DY + 1);
    localparam int GW  = $clog2(GAP);

    logic [PXW-1:0]   px;
    logic [PYW-1:0]   py;
    logic             eof, de_ok, px_last, close, full, empty, drop, rd, avail;
    logic             wait_end, row_end, frame_end, wb_q;
    logic [ACC_W-1:0] acc [DX];
    logic [DX-1:0]    raw, row_bits, rdata;
    logic [CW-1:0]    col;
    logic [RW-1:0]    r;
    logic [GW-1:0]    wcnt;
    state_t           state, next;

    // eof blocks pixels beyond the last frame row until the next vsync
    assign de_ok     = i_de && !i_vsync && !eof;
    assign px_last   = px == PXW'(W - 1);
    assign close     = de_ok && px_last && &py[CELL_LOG2-1:0];
    assign avail     = !empty || (close && !full);
    assign wait_end  = wcnt == GW'(GAP - 2);
    assign row_end   = col == CW'(DX - 1);
    assign frame_end = state == S_WAIT && wait_end && r == RW'(DY);
    assign o_valid   = state == S_EMIT;
    assign o_wb      = o_valid ? rdata[col] : wb_q;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || i_vsync) begin
            px  <= '0;
            py  <= '0;
            eof <= 1'b0;
            for (int k = 0; k < DX; k++) acc[k] <= '0;
        end else if (de_ok) begin
            px <= px_last ? '0 : px + 1'b1;
            if (px_last) begin
                py  <= py == PYW'(H - 1) ? '0 : py + 1'b1;
                eof <= py == PYW'(H - 1);
            end
            for (int k = 0; k < DX; k++)
                if (close) acc[k] <= '0;
                else if (i_bin && px[PXW-1:CELL_LOG2] == KW'(k) && acc[k] != '1) acc[k] <= acc[k] + 1'b1;
        end
    end

    // the last cell's closing pixel has not reached its accumulator yet
    always_comb begin
        raw = '0;
        for (int k = 0; k < DX; k++)
            raw[k] = ({1'b0, acc[k]} + {{ACC_W{1'b0}}, (k == DX - 1) && i_bin}) >= {1'b0, i_thresh};
    end

`ifdef CORROSION_ERODE_EN
    assign row_bits = raw & (raw << 1) & (raw >> 1);
`else
    assign row_bits = raw;
`endif

    corrosion_row_fifo #(.DX(DX)) u_fifo (
        .clk   (sys_clk),
        .rst_n (sys_rst_n),
        .clr   (i_vsync),
        .wr    (close),
        .wdata (row_bits),
        .rd    (rd),
        .rdata (rdata),
        .full  (full),
        .empty (empty),
        .drop  (drop)
    );

    always_ff @(posedge sys_clk) state <= !sys_rst_n ? S_IDLE : next;

    always_comb begin
        next = state;
        rd   = 1'b0;
        if (i_vsync) next = S_IDLE;
        else
            case (state)
                S_IDLE:  next = avail ? S_EMIT : S_IDLE;
                S_EMIT: begin
                    next = S_WAIT;
                    rd   = row_end;
                end
                S_WAIT:  if (wait_end) next = (!frame_end && avail) ? S_EMIT : S_IDLE;
                default: next = S_IDLE;
            endcase
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || i_vsync) begin
            col          <= '0;
            r            <= '0;
            wcnt         <= '0;
            o_frame_done <= 1'b0;
            o_ovf        <= 1'b0;
            if (!sys_rst_n) wb_q <= 1'b0;
        end else begin
            o_frame_done <= frame_end;
            if (drop) o_ovf <= 1'b1;
            if (o_valid) begin
                wb_q <= rdata[col];
                col  <= row_end ? '0 : col + 1'b1;
                if (row_end) r <= r + 1'b1;
            end
            if (frame_end) r <= '0;
            wcnt <= (state == S_WAIT && !wait_end) ? wcnt + 1'b1 : '0;
        end
    end
endmodule

// File: tb/tb_corrosion_grid.sv
// tb_corrosion_grid: directed checks of corrosion_grid on a 4x2-cell grid of 2x2-pixel cells.
module tb_corrosion_grid;
    import corrosion_grid_pkg::*;

`ifdef CORROSION_ERODE_EN
    localparam logic [7:0] WHITE = 8'h66;
    localparam logic [7:0] T2    = 8'h00;
    localparam logic [7:0] T5    = 8'h02;
`else
    localparam logic [7:0] WHITE = 8'hFF;
    localparam logic [7:0] T2    = 8'h82;
    localparam logic [7:0] T5    = 8'h87;
`endif

    logic       sys_clk = 1'b0, sys_rst_n = 1'b0, i_vsync = 1'b0, i_de = 1'b0, i_bin = 1'b0;
    logic [2:0] i_thresh = 3'd2;
    logic       o_valid, o_wb, o_frame_done, o_ovf;
    logic       v_valid, v_wb, v_frame_done, v_ovf;
    logic       vq[$];
    int         tq[$];
    int         cyc = 0, cc = 0, fd = 0, fd_cyc = 0, ov_n = 0, ov_fd = 0, passed = 0, total = 0;

    corrosion_grid #(.CELL_LOG2(1), .DX(4), .DY(2), .GAP(6), .ACC_W(3)) u_dut (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_vsync(i_vsync), .i_de(i_de), .i_bin(i_bin),
        .i_thresh(i_thresh), .o_valid(o_valid), .o_wb(o_wb), .o_frame_done(o_frame_done), .o_ovf(o_ovf)
    );

    // slower, taller twin so three cell rows can close while the first is still draining
    corrosion_grid #(.CELL_LOG2(1), .DX(4), .DY(3), .GAP(12), .ACC_W(3)) u_ovf (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .i_vsync(i_vsync), .i_de(i_de), .i_bin(i_bin),
        .i_thresh(i_thresh), .o_valid(v_valid), .o_wb(v_wb), .o_frame_done(v_frame_done), .o_ovf(v_ovf)
    );

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        if (o_valid) begin
            vq.push_back(o_wb);
            tq.push_back(cyc);
        end
        if (o_frame_done) begin
            fd++;
            fd_cyc = cyc;
        end
        if (v_valid) ov_n++;
        if (v_frame_done) ov_fd++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic pixel(input logic b);
        i_de  = 1'b1;
        i_bin = b;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic frame(input logic [31:0] p);
        for (int i = 0; i < 32; i++) begin
            if (i == 15) cc = cyc;
            pixel(p[i]);
        end
        i_de = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic vsync();
        i_vsync = 1'b1;
        @(posedge sys_clk);
        #1;
        i_vsync = 1'b0;
        vq.delete();
        tq.delete();
        fd    = 0;
        ov_n  = 0;
        ov_fd = 0;
    endtask

    function automatic logic [7:0] emitted();
        logic [7:0] v = '0;
        for (int i = 0; i < vq.size() && i < 8; i++) v[i] = vq[i];
        return v;
    endfunction

    initial begin
        int bad;
        idle(3);
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_wb", 32'(o_wb), 0);
        chk("rst_done", 32'(o_frame_done), 0);
        chk("rst_ovf", 32'(o_ovf), 0);
        sys_rst_n = 1'b1;
        idle(2);

        vsync();
        frame(32'hFFFF_FFFF);
        idle(60);
        chk("t1_count", vq.size(), 8);
        chk("t1_bits", 32'(emitted()), 32'(WHITE));
        chk("t1_latency", tq[0], cc + 1);
        bad = 0;
        for (int i = 1; i < tq.size(); i++) if (tq[i] - tq[i-1] != 6) bad++;
        chk("t1_spacing", bad, 0);
        chk("t1_done_n", fd, 1);
        chk("t1_done_cyc", fd_cyc, tq[7] + 6);
        chk("t1_ovf", 32'(o_ovf), 0);

        vsync();
        frame(32'hC000_0805);
        idle(60);
        chk("t2_count", vq.size(), 8);
        chk("t2_bits", 32'(emitted()), 32'(T2));

        vsync();
        frame(32'hC000_BF3F);
        idle(60);
        chk("t5_count", vq.size(), 8);
        chk("t5_bits", 32'(emitted()), 32'(T5));

        vsync();
        for (int i = 0; i < 48; i++) begin
            pixel(1'b1);
            if (i == 31) chk("t3_ovf_before", 32'(v_ovf), 0);
            if (i == 47) chk("t3_ovf_set", 32'(v_ovf), 1);
        end
        i_de = 1'b0;
        idle(90);
        chk("t3_main_ovf", 32'(o_ovf), 0);
        chk("t3_ovf_cells", ov_n, 8);
        chk("t3_ovf_done", ov_fd, 0);
        chk("t3_main_cells", vq.size(), 8);
        chk("t3_main_done", fd, 1);
        vsync();
        chk("t3_ovf_clear", 32'(v_ovf), 0);

        for (int i = 0; i < 13; i++) pixel(1'b1);
        i_de = 1'b0;
        vsync();
        idle(30);
        chk("t4_aborted", vq.size(), 0);
        frame(32'hFFFF_FFFF);
        idle(60);
        chk("t4_count", vq.size(), 8);
        chk("t4_bits", 32'(emitted()), 32'(WHITE));
        chk("t4_done", fd, 1);

        vsync();
        for (int i = 0; i < 16; i++) pixel(1'b1);
        i_de = 1'b0;
        chk("t6_emitting", 32'(o_valid), 1);
        sys_rst_n = 1'b0;
        idle(1);
        sys_rst_n = 1'b1;
        chk("t6_valid", 32'(o_valid), 0);
        chk("t6_state", 32'(u_dut.state), 32'(S_IDLE));
        vq.delete();
        tq.delete();
        fd = 0;
        idle(30);
        chk("t6_quiet", vq.size(), 0);
        frame(32'hFFFF_FFFF);
        idle(60);
        chk("t6_count", vq.size(), 8);
        chk("t6_bits", 32'(emitted()), 32'(WHITE));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
